// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, controller states and the iteration count.
package mdu_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement of a W-bit value.
// Used for operand magnitudes and for result sign fix-up.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? (-x) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// One iteration per cycle, fixed 33-cycle latency for all ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = mdu_pkg::ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e state, state_n;

  logic [5:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] wlo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;
  logic             done_q;

  op_e              op_in;
  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_in  = op_e'(op);
  assign sgn_op = (op_in == OP_MULT) ||
                  (op_in == OP_DIV);
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign last   = (cnt == 6'(ITER - 1));

  mdu_negate #(.W(WIDTH)) u_neg_a (
    .en (sa),
    .x  (a),
    .y  (a_mag)
  );

  mdu_negate #(.W(WIDTH)) u_neg_b (
    .en (sb),
    .x  (b),
    .y  (b_mag)
  );

  // Multiply step: acc holds the upper half, wlo the multiplier.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;

  assign addend  = wlo[0] ? mcand : '0;
  assign mul_sum = {1'b0, acc} + {1'b0, addend};

  // Divide step: acc holds the remainder, wlo the quotient.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  assign div_sh   = {acc, wlo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mcand};
  assign div_ok   = ~div_diff[WIDTH];
  assign rem_n    = div_ok ? div_diff[WIDTH-1:0]
                           : div_sh[WIDTH-1:0];
  assign quo_n    = {wlo[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_negate #(.W(2*WIDTH)) u_neg_p (
    .en (neg_res),
    .x  ({acc, wlo}),
    .y  (prod_fix)
  );

  mdu_negate #(.W(WIDTH)) u_neg_q (
    .en (neg_res),
    .x  (wlo),
    .y  (quo_fix)
  );

  mdu_negate #(.W(WIDTH)) u_neg_r (
    .en (neg_rem),
    .x  (acc),
    .y  (rem_fix)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last)  state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      wlo     <= '0;
      mcand   <= '0;
      a_orig  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (mthi) hi_q <= a;
          if (mtlo) lo_q <= a;
          if (start) begin
            cnt     <= '0;
            acc     <= '0;
            wlo     <= a_mag;
            mcand   <= b_mag;
            a_orig  <= a;
            is_div  <= op[1];
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            b_zero  <= (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (is_div) begin
            acc <= rem_n;
            wlo <= quo_n;
          end else begin
            acc <= mul_sum[WIDTH:1];
            wlo <= {mul_sum[0], wlo[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Divide by zero reports all-ones quotient, dividend as remainder.
          unique case (1'b1)
            is_div && b_zero: begin
              lo_q <= '1;
              hi_q <= a_orig;
            end
            is_div && !b_zero: begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
            !is_div: begin
              {hi_q, lo_q} <= prod_fix;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit sitting beside the ALU in the execute stage of the MIPS core. It consumes the two register-file operands (rs, rt) that also feed the ALU and produces the architectural HI/LO registers. A small controller reads HI/LO back into the write-back result path (MFHI/MFLO) and stalls the PC while `busy` is high. It implements MULT, MULTU, DIV and DIVU with a 32-iteration shift-add / restoring-divide engine, plus the MTHI and MTLO writes.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is verified
- ITER, WIDTH, iteration count; fixed equal to WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  begin operation `op` on operands `a`/`b`; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand or dividend)
- b  in  WIDTH  rt operand (multiplier or divisor)
- mthi  in  1  write `a` into HI
- mtlo  in  1  write `a` into LO
- hi  out  WIDTH  HI register (remainder or upper product)
- lo  out  WIDTH  LO register (quotient or lower product)
- busy  out  1  operation in progress; the controller stalls the PC
- done  out  1  one-cycle pulse when HI/LO have been updated by an operation

## Operation
- Reset (`reset` = 0): state IDLE; hi = 0, lo = 0, busy = 0, done = 0, counter = 0. Applied asynchronously, including mid-operation: the operation is aborted with no `done` and HI/LO are cleared.
- States:
  - IDLE: if `start` is high, latch operands, op and the sign flags, and go to CALC.
  - CALC: perform one iteration per cycle for ITER cycles, then go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Signed ops (MULT, DIV): at the IDLE→CALC edge, latch |a| and |b| and the sign flags. The magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- Multiply: 64-bit {acc, mplier}; each step adds the multiplicand to acc when the LSB is 1, then shifts right by 1.
  - FIX: negate the 64-bit product if sign(a) ≠ sign(b).
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division; each step shifts {rem, quot} left, subtracts the divisor, and restores if the result is negative.
  - FIX: quotient is negated if sign(a) ≠ sign(b); remainder takes the sign of `a`.
  - LO = quotient, HI = remainder.
- Divide by zero (b = 0, signed or unsigned): LO = 0xFFFFFFFF, HI = the original `a`. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI / MTLO:
  - In IDLE: written at the clock edge.
  - Asserted in the same cycle as `start`: the write happens, and the operation result later overwrites it.
  - While busy: ignored.
- `start` while busy: ignored; no queueing.
- `hi`/`lo` hold their previous values throughout CALC and FIX, and change only at the FIX→IDLE edge.

## Timing
- `start` is sampled at edge k (IDLE).
  - `busy` = 1 from after edge k through the cycle before edge k+33.
  - Edges k+1 … k+32 perform iterations 1 … 32.
  - Edge k+33 is the FIX edge: HI/LO are updated, `done` = 1 and `busy` = 0 for exactly the cycle after edge k+33.
- Latency from `start` edge to valid HI/LO: 33 cycles, for every op and for all operand values.
- Back-to-back: a new `start` is accepted in the cycle where `done` = 1 (state is IDLE), so the next operation begins at edge k+34.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mdu_pkg`:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, CALC, FIX
  - constant ITER = 32
- Sub-module `mdu_negate`: combinational conditional two's-complement on a parameterized width. Instantiated for operand magnitudes (32-bit) and result fix-up (64-bit product; 32-bit quotient/remainder).
- The 6-bit iteration counter and the datapath registers live in `mult_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done exactly 33 cycles after start; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7 → LO = 14, HI = 2; DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIVU 0x64 / 0 and DIV −5 / 0 → LO = 0xFFFFFFFF, HI = original `a`; latency 33 cycles.
- MTHI 0x1234 in IDLE → HI = 0x1234 next cycle. MTLO, and a second `start` with different operands, during busy → both ignored; the result reflects only the first op.
- Start MULTU, drive `reset` low at iteration 10 → busy = 0 and HI = LO = 0 immediately (asynchronous); `done` never pulses; a new op after reset release completes correctly.
